// File: rtl/reg_acc_mac.sv
// reg_acc_mac: parametrised accumulator register with legacy load/inc/clear,
// add-accumulate, decrement, sticky overflow and a dot-product sequencer.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   i_start     begin a dot-product run (honoured only in IDLE)
//   i_mux_load  load i_mux_in
//   i_alu_load  load i_alu_in
//   i_acc_en    accumulate i_alu_in
//   i_inc       increment
//   i_dec       decrement
//   i_clear     zero the accumulator; aborts a run
//   i_alu_in    ALU/multiplier result
//   i_mux_in    bus-mux data
//   o_data_out  accumulator value
//   o_count     accumulate beats completed in the current run
//   o_busy      high while accumulating a run
//   o_done      one-cycle pulse at the end of a run
//   o_ovf       sticky unsigned carry/borrow flag
//
// Optional feature: define REG_ACC_SAT_EN to make acc/inc saturate at all
// ones and dec saturate at zero (ovf still sets on saturation).
module reg_acc_mac #(
    parameter int WIDTH = 16,
    parameter int TERMS = 4,
    localparam int CW = $clog2(TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mux_load,
    input  logic             i_alu_load,
    input  logic             i_acc_en,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_alu_in,
    input  logic [WIDTH-1:0] i_mux_in,
    output logic [WIDTH-1:0] o_data_out,
    output logic [CW-1:0]    o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_data, w_nxt_data;
    logic [CW-1:0]    r_count, w_nxt_count;
    logic             r_ovf, w_nxt_ovf;
    logic [WIDTH-1:0] w_addend, w_add_res, w_dec_res;
    logic [WIDTH:0]   w_sum;
    logic             w_borrow;
    // One adder serves both accumulate and increment; acc_en outranks inc.
    assign w_addend = i_acc_en ? i_alu_in : WIDTH'(1);
    assign w_sum    = {1'b0, r_data} + {1'b0, w_addend};
    assign w_borrow = (r_data == '0);
`ifdef REG_ACC_SAT_EN
    assign w_add_res = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    assign w_dec_res = w_borrow ? '0 : r_data - WIDTH'(1);
`else
    assign w_add_res = w_sum[WIDTH-1:0];
    assign w_dec_res = r_data - WIDTH'(1);
`endif
    always_comb begin
        w_next      = r_state;
        w_nxt_data  = r_data;
        w_nxt_count = r_count;
        w_nxt_ovf   = r_ovf;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nxt_data  = '0;
                    w_nxt_count = '0;
                    w_nxt_ovf   = 1'b0;
                    w_next      = ACCUM;
                end else if (i_mux_load) begin
                    w_nxt_data = i_mux_in;
                    w_nxt_ovf  = 1'b0;
                end else if (i_alu_load) begin
                    w_nxt_data = i_alu_in;
                    w_nxt_ovf  = 1'b0;
                end else if (i_acc_en || i_inc) begin
                    w_nxt_data = w_add_res;
                    w_nxt_ovf  = r_ovf | w_sum[WIDTH];
                end else if (i_dec) begin
                    w_nxt_data = w_dec_res;
                    w_nxt_ovf  = r_ovf | w_borrow;
                end else if (i_clear) begin
                    w_nxt_data  = '0;
                    w_nxt_count = '0;
                    w_nxt_ovf   = 1'b0;
                end
            end
            ACCUM: begin
                if (i_clear) begin
                    w_nxt_data  = '0;
                    w_nxt_count = '0;
                    w_nxt_ovf   = 1'b0;
                    w_next      = IDLE;
                end else if (i_acc_en) begin
                    w_nxt_data  = w_add_res;
                    w_nxt_ovf   = r_ovf | w_sum[WIDTH];
                    w_nxt_count = r_count + CW'(1);
                    w_next      = (r_count == CW'(TERMS - 1)) ? DONE : ACCUM;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_data  <= w_nxt_data;
            r_count <= w_nxt_count;
            r_ovf   <= w_nxt_ovf;
        end
    end
    // busy/done decode straight from state so async reset clears them at once.
    assign o_data_out = r_data;
    assign o_count    = r_count;
    assign o_ovf      = r_ovf;
    assign o_busy     = (r_state == ACCUM);
    assign o_done     = (r_state == DONE);
endmodule

// File: doc/reg_acc_mac.md
Name: reg_acc_mac

Overview:
- Parametrised successor of the 16-bit accumulator register (AC) used by the matrix-multiplier datapath.
- Keeps the legacy load/inc/clear controls and adds an add-accumulate path, decrement, a sticky overflow flag and a built-in dot-product sequencer.
- The sequencer sums exactly TERMS products, then pulses done.
- Sits between the ALU/multiplier output and the result-write mux.

Parameters:
- WIDTH, 16, data width of accumulator and input buses (>=2).
- TERMS, 4, number of accumulate beats per dot-product run (>=1).
- CW (localparam), $clog2(TERMS+1), width of count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin dot-product run; honoured only in IDLE.
- mux_load  in  1  load mux_in.
- alu_load  in  1  load alu_in.
- acc_en  in  1  data_out <= data_out + alu_in.
- inc  in  1  data_out <= data_out + 1.
- dec  in  1  data_out <= data_out - 1.
- clear  in  1  zero data_out; aborts a run.
- alu_in  in  WIDTH  ALU/multiplier result.
- mux_in  in  WIDTH  bus-mux data.
- data_out  out  WIDTH  accumulator value.
- count  out  CW  accumulate beats completed in current run.
- busy  out  1  high in ACCUM.
- done  out  1  one-cycle pulse at end of run.
- ovf  out  1  sticky unsigned carry/borrow flag.

Behaviour:
- Reset (async, any state): data_out=0, count=0, busy=0, done=0, ovf=0, state=IDLE.
- State machine: IDLE, ACCUM, DONE. All updates occur on posedge clk; results are visible the next cycle.
- IDLE, start=0: single-operation priority mux_load > alu_load > acc_en > inc > dec > clear > hold. This matches the legacy order; acc_en and dec are inserted.
- IDLE, start=1: start wins over every other control. Effects: data_out=0, count=0, ovf=0, state->ACCUM.
- ACCUM: busy=1.
  - clear=1: data_out=0, count=0, state->IDLE, no done pulse. clear has top priority in ACCUM.
  - Otherwise acc_en=1: add alu_in and count+1. If count was TERMS-1, state->DONE.
  - acc_en=0: hold (stall allowed, unlimited).
  - mux_load, alu_load, inc, dec and start are ignored in ACCUM.
- DONE: lasts one cycle. done=1, busy=0, data_out holds the final sum, count=TERMS. Controls are ignored. Next state is IDLE.
- count holds its value in IDLE until the next start or clear.
- Arithmetic: unsigned, modulo 2^WIDTH by default.
  - ovf sets on carry-out of acc_en/inc, or on borrow of dec (0-1 -> all ones).
  - ovf clears only on rst, start, mux_load, alu_load or clear. Loads taken in IDLE always clear ovf.
- TERMS=1: a single acc_en beat moves ACCUM->DONE.
- rst asserted mid-run: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro REG_ACC_SAT_EN.
- Defined: acc_en and inc saturate at 2^WIDTH-1, and dec saturates at 0. ovf still sets when saturation occurs.
- Undefined: wrap-around as above. No extra logic is built.

Test Plan:
- Legacy priority: IDLE, data_out=5; mux_load=1, alu_load=1, inc=1, mux_in=0x00AA, alu_in=0x0011 -> data_out=0x00AA next cycle. Then inc only -> 0x00AB. Then clear -> 0.
- Dot product, TERMS=4, WIDTH=16: start; then acc_en with alu_in 3, 5, 7, 9 on consecutive cycles, with one stall cycle after 5.
  - busy is high for 5 cycles, count steps 1..4.
  - done pulses exactly one cycle after the 4th beat, with data_out=24 and ovf=0.
- Overflow/wrap (macro off): alu_load 0xFFFF, then inc -> data_out=0x0000, ovf=1. Then dec -> 0xFFFF, ovf stays 1. Then mux_load 1 -> ovf=0.
- Saturation (REG_ACC_SAT_EN): alu_load 0xFFF0, acc_en alu_in=0x0020 -> data_out=0xFFFF, ovf=1. From 0, dec -> data_out=0, ovf=1.
- Abort/ignore: mid-run after 2 beats, assert start+inc -> ignored. Then clear -> data_out=0, count=0, busy=0 next cycle, no done pulse.
- Async reset mid-run: assert rst between clock edges during ACCUM -> all outputs 0 immediately, before the next clock edge. After release, IDLE; start is accepted on the next cycle.
